mrv32_mem_arb: RTL

//   Shares the single blocking memory port between instruction fetch (read-only) and the LSU
//   (read/write). Each requester pulses a request; the arbiter buffers it in a 1-entry
//   per-port slot, grants by priority with anti-starvation, tracks the single outstanding

---
 rtl/mrv32_mem_arb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mrv32_mem_arb.sv
// Memory port arbiter for mrv32: buffers fetch/LSU request pulses in one-entry slots,
// grants with data priority plus anti-starvation, routes the single outstanding read back.
module mrv32_mem_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int STARVE_MAX = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_valid,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic [31:0]           d_rdata,
    output logic                  d_rvalid,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_rvalid,
    output logic                  m_valid,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    input  logic [31:0]           m_rdata,
    input  logic                  m_rvalid,
    output logic                  rd_timeout,
    output logic                  proto_err,
    output logic                  busy
);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  d_full_r;
    logic [ADDR_WIDTH-1:0] d_addr_r;
    logic [31:0]           d_wdata_r;
    logic [3:0]            d_wstrb_r;
    logic                  i_full_r;
    logic [ADDR_WIDTH-1:0] i_addr_r;
    logic [SW-1:0]         starve_cnt_r;
    logic [TW-1:0]         tmo_cnt_r;
    logic                  owner_i_r;
    logic                  proto_err_r;
    logic                  grant_d_s;
    logic                  grant_i_s;
    logic                  issue_rd_s;
    logic                  tmo_hit_s;

    // Grant selection: data first, fetch once the starvation budget is spent
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            if (i_full_r && (!d_full_r ||
                    ((STARVE_MAX != 0) && (starve_cnt_r == SW'(STARVE_MAX))))) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = d_full_r;
            end
        end else begin
            grant_d_s = 1'b0;
        end
        issue_rd_s = grant_i_s || (grant_d_s && (d_wstrb_r == 4'b0000));
        tmo_hit_s  = (RD_TIMEOUT != 0) && (tmo_cnt_r == TW'(RD_TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = issue_rd_s ? RD_WAIT : IDLE;
            RD_WAIT: state_nxt_s = (m_rvalid || tmo_hit_s) ? IDLE : RD_WAIT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: memory strobe from the granted slot, response routed to the read owner
    always_comb begin
        m_valid    = grant_d_s || grant_i_s;
        m_addr     = {ADDR_WIDTH{1'b0}};
        m_wdata    = 32'h0000_0000;
        m_wstrb    = 4'b0000;
        d_rvalid   = 1'b0;
        d_rdata    = 32'h0000_0000;
        i_rvalid   = 1'b0;
        i_rdata    = 32'h0000_0000;
        rd_timeout = 1'b0;
        if (grant_i_s) begin
            m_addr = i_addr_r;
        end else if (grant_d_s) begin
            m_addr  = d_addr_r;
            m_wdata = d_wdata_r;
            m_wstrb = d_wstrb_r;
        end else begin
            m_addr = {ADDR_WIDTH{1'b0}};
        end
        if ((state_r == RD_WAIT) && (m_rvalid || tmo_hit_s)) begin
            // a real return beats the watchdog in the same cycle
            rd_timeout = !m_rvalid;
            if (owner_i_r) begin
                i_rvalid = 1'b1;
                i_rdata  = m_rvalid ? m_rdata : 32'h0000_0000;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = m_rvalid ? m_rdata : 32'h0000_0000;
            end
        end else begin
            rd_timeout = 1'b0;
        end
        proto_err = proto_err_r;
        busy      = (state_r != IDLE) || d_full_r || i_full_r;
    end

    // Request slots, starvation/watchdog counters and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_full_r     <= 1'b0;
            d_addr_r     <= {ADDR_WIDTH{1'b0}};
            d_wdata_r    <= 32'h0000_0000;
            d_wstrb_r    <= 4'b0000;
            i_full_r     <= 1'b0;
            i_addr_r     <= {ADDR_WIDTH{1'b0}};
            starve_cnt_r <= {SW{1'b0}};
            tmo_cnt_r    <= {TW{1'b0}};
            owner_i_r    <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            if (d_valid && (!d_full_r || grant_d_s)) begin
                d_full_r  <= 1'b1;
                d_addr_r  <= d_addr;
                d_wdata_r <= d_wdata;
                d_wstrb_r <= d_wstrb;
            end else if (d_valid) begin
                proto_err_r <= 1'b1;
            end else if (grant_d_s) begin
                d_full_r <= 1'b0;
            end
            if (i_valid && (!i_full_r || grant_i_s)) begin
                i_full_r <= 1'b1;
                i_addr_r <= i_addr;
            end else if (i_valid) begin
                proto_err_r <= 1'b1;
            end else if (grant_i_s) begin
                i_full_r <= 1'b0;
            end
            if (grant_i_s) begin
                starve_cnt_r <= {SW{1'b0}};
            end else if (grant_d_s && i_full_r && (starve_cnt_r != SW'(STARVE_MAX))) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end
            if (issue_rd_s) begin
                tmo_cnt_r <= {TW{1'b0}};
                owner_i_r <= grant_i_s;
            end else if ((state_r == RD_WAIT) && !m_rvalid) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end
endmodule
